// File: rtl/vscale_fetch_unit.sv
// Fetch front end: one outstanding imem request, registered PC_IF/inst_IF to decode; resp->inst_valid_IF is 1 cycle.
// Backpressure: stall_IF holds the output register and blocks new requests; redirect kills held or in-flight fetches.
module vscale_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0200,
    parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_PIF,
    input  logic        redirect,
    input  logic        stall_IF,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_badmem_e,
    output logic [31:0] PC_IF,
    output logic [31:0] inst_IF,
    output logic        inst_valid_IF,
    output logic        fetch_fault_IF
);

    typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] pend_pc, pend_pc_n;
    logic        drop, drop_n;
    logic [31:0] pc_if_n, inst_if_n;
    logic        valid_n, fault_n;
    logic [31:0] redirect_pc;

    assign redirect_pc    = PC_PIF & ~32'h3;
    assign imem_addr      = fetch_pc;
    assign imem_req_valid = (state == S_REQ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_BOOT;
            fetch_pc       <= RESET_VECTOR;
            pend_pc        <= RESET_VECTOR;
            drop           <= 1'b0;
            PC_IF          <= RESET_VECTOR;
            inst_IF        <= NOP_INST;
            inst_valid_IF  <= 1'b0;
            fetch_fault_IF <= 1'b0;
        end else begin
            state          <= state_n;
            fetch_pc       <= fetch_pc_n;
            pend_pc        <= pend_pc_n;
            drop           <= drop_n;
            PC_IF          <= pc_if_n;
            inst_IF        <= inst_if_n;
            inst_valid_IF  <= valid_n;
            fetch_fault_IF <= fault_n;
        end
    end

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        pend_pc_n  = pend_pc;
        drop_n     = drop;
        pc_if_n    = PC_IF;
        inst_if_n  = inst_IF;
        valid_n    = inst_valid_IF;
        fault_n    = fetch_fault_IF;
        case (state)
            S_BOOT: begin
                if (redirect) fetch_pc_n = redirect_pc;
                state_n = S_REQ;
            end
            S_REQ: begin
                if (imem_req_ready) begin
                    // The accepted request carries the old address; a same-cycle redirect marks its response dead.
                    pend_pc_n = fetch_pc;
                    state_n   = S_WAIT;
                    if (redirect) begin
                        drop_n     = 1'b1;
                        fetch_pc_n = redirect_pc;
                    end
                end else if (redirect) begin
                    fetch_pc_n = redirect_pc;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (drop || redirect) begin
                        drop_n  = 1'b0;
                        state_n = S_REQ;
                        if (redirect) fetch_pc_n = redirect_pc;
                    end else begin
                        pc_if_n    = pend_pc;
                        inst_if_n  = imem_badmem_e ? NOP_INST : imem_resp_data;
                        fault_n    = imem_badmem_e;
                        valid_n    = 1'b1;
                        fetch_pc_n = pend_pc + 32'd4;
                        state_n    = S_HOLD;
                    end
                end else if (redirect) begin
                    drop_n     = 1'b1;
                    fetch_pc_n = redirect_pc;
                end
            end
            S_HOLD: begin
                if (redirect || !stall_IF) begin
                    valid_n = 1'b0;
                    fault_n = 1'b0;
                    state_n = S_REQ;
                    if (redirect) fetch_pc_n = redirect_pc;
                end
            end
            default: state_n = S_BOOT;
        endcase
    end

endmodule

// File: tb/tb_vscale_fetch_unit.sv
// Bench for vscale_fetch_unit: acts as imem and decode, predicts the delivered instruction stream.
module tb_vscale_fetch_unit;

    localparam logic [31:0] RV  = 32'h0000_0200;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, reset, redirect, stall_IF;
    logic        imem_req_valid, imem_req_ready, imem_resp_valid, imem_badmem_e;
    logic        inst_valid_IF, fetch_fault_IF;
    logic [31:0] PC_PIF, imem_addr, imem_resp_data, PC_IF, inst_IF;

    vscale_fetch_unit dut (
        .clk(clk), .reset(reset), .PC_PIF(PC_PIF), .redirect(redirect), .stall_IF(stall_IF),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .imem_badmem_e(imem_badmem_e), .PC_IF(PC_IF), .inst_IF(inst_IF),
        .inst_valid_IF(inst_valid_IF), .fetch_fault_IF(fetch_fault_IF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    // Model: instructions owed to decode, address of the next expected request, in-flight bookkeeping.
    exp_t        exp_q[$];
    logic [31:0] hs_log[$];
    logic [31:0] dlv_log[$];
    logic [31:0] exp_next, pend, mem_addr;
    bit          outstanding, killed, mem_busy;
    int          mem_cnt, lat_lo, lat_hi;
    int          n_checks, n_errors;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        hs_log.delete();
        dlv_log.delete();
        exp_next    = RV;
        outstanding = 0;
        killed      = 0;
        mem_busy    = 0;
        mem_cnt     = 0;
    endtask

    task automatic drive_idle();
        redirect = 0; PC_PIF = '0; stall_IF = 0; imem_req_ready = 0;
        imem_resp_valid = 0; imem_resp_data = '0; imem_badmem_e = 0;
    endtask

    // One clock: check decode-side outputs against the model, then drive inputs for the next edge.
    task automatic step(input bit rd, input logic [31:0] tgt, input bit stl, input bit rdy, input bit bad);
        bit   hs, rsp;
        exp_t e;
        @(negedge clk);
        n_checks++;
        if (inst_valid_IF !== (exp_q.size() != 0)) begin
            n_errors++;
            $display("FAIL inst_valid: got %b expected %b", inst_valid_IF, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            if (PC_IF !== exp_q[0].pc || inst_IF !== exp_q[0].inst || fetch_fault_IF !== exp_q[0].fault) begin
                n_errors++;
                $display("FAIL out_word: got pc=%h inst=%h fault=%b expected pc=%h inst=%h fault=%b",
                         PC_IF, inst_IF, fetch_fault_IF, exp_q[0].pc, exp_q[0].inst, exp_q[0].fault);
            end
        end else begin
            n_checks++;
            if (fetch_fault_IF !== 1'b0) begin
                n_errors++;
                $display("FAIL fault_idle: got %b expected 0", fetch_fault_IF);
            end
        end
        if (imem_req_valid === 1'b1) begin
            n_checks++;
            if (outstanding || exp_q.size() != 0 || imem_addr[1:0] !== 2'b00) begin
                n_errors++;
                $display("FAIL req_legal: got req with outstanding=%0d held=%0d addr=%h expected none",
                         outstanding, exp_q.size(), imem_addr);
            end
        end
        rsp = mem_busy && (mem_cnt == 0);
        redirect        = rd;
        PC_PIF          = tgt;
        stall_IF        = stl;
        imem_req_ready  = rdy;
        imem_resp_valid = rsp;
        imem_resp_data  = rsp ? mem_word(mem_addr) : $urandom;
        imem_badmem_e   = rsp ? bad : 1'($urandom);
        hs = (imem_req_valid === 1'b1) && rdy;
        if (rsp) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (exp_q.size() != 0 && (rd || !stl)) void'(exp_q.pop_front());
        if (hs) begin
            n_checks++;
            if (imem_addr !== exp_next) begin
                n_errors++;
                $display("FAIL req_addr: got %h expected %h", imem_addr, exp_next);
            end
            hs_log.push_back(imem_addr);
            mem_busy    = 1;
            mem_cnt     = $urandom_range(lat_hi, lat_lo);
            mem_addr    = imem_addr;
            outstanding = 1;
            killed      = rd;
            pend        = imem_addr;
        end else if (rsp) begin
            if (!(killed || rd)) begin
                e.pc    = pend;
                e.inst  = bad ? NOP : mem_word(pend);
                e.fault = bad;
                exp_q.push_back(e);
                dlv_log.push_back(pend);
                exp_next = pend + 32'd4;
            end
            outstanding = 0;
        end else if (outstanding && rd) begin
            killed = 1;
        end
        if (rd) exp_next = tgt & ~32'h3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        drive_idle();
        clear_model();
        @(negedge clk);
        reset = 0;
    endtask

    task automatic run_until_hs(input int n, input bit stl);
        for (int i = 0; i < 200 && hs_log.size() < n; i++) step(0, '0, stl, 1, 0);
        n_checks++;
        if (hs_log.size() < n) begin
            n_errors++;
            $display("FAIL hs_timeout: got %0d requests expected %0d", hs_log.size(), n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1;
        drive_idle();
        clear_model();
        #1;
        n_checks++;
        if (PC_IF !== RV || inst_IF !== NOP || inst_valid_IF !== 1'b0 ||
            fetch_fault_IF !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_vals: got pc=%h inst=%h v=%b f=%b req=%b expected %h %h 0 0 0",
                     PC_IF, inst_IF, inst_valid_IF, fetch_fault_IF, imem_req_valid, RV, NOP);
        end
        @(negedge clk);
        reset = 0;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL boot_noreq: got %b expected 0", imem_req_valid);
        end
        step(0, '0, 0, 0, 0);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RV) begin
            n_errors++;
            $display("FAIL first_req: got v=%b addr=%h expected 1 %h", imem_req_valid, imem_addr, RV);
        end
    endtask

    task automatic test_sequential();
        lat_lo = 0; lat_hi = 0;
        do_reset();
        run_until_hs(4, 0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (hs_log.size() < 4 || dlv_log.size() < 3 ||
                hs_log[i] !== RV + 32'(4 * i) || dlv_log[i] !== RV + 32'(4 * i)) begin
                n_errors++;
                $display("FAIL seq_addr%0d: got req=%h dlv=%h expected %h", i,
                         hs_log.size() > i ? hs_log[i] : 32'hx, dlv_log.size() > i ? dlv_log[i] : 32'hx,
                         RV + 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        exp_t snap;
        lat_lo = 1; lat_hi = 1;
        do_reset();
        for (int i = 0; i < 50 && exp_q.size() == 0; i++) step(0, '0, 1, 1, 0);
        snap = exp_q.size() != 0 ? exp_q[0] : '0;
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 1, 1, 0);
            n_checks++;
            if (inst_valid_IF !== 1'b1 || imem_req_valid !== 1'b0 || PC_IF !== snap.pc || inst_IF !== snap.inst) begin
                n_errors++;
                $display("FAIL stall_hold%0d: got v=%b req=%b pc=%h inst=%h expected 1 0 %h %h",
                         i, inst_valid_IF, imem_req_valid, PC_IF, inst_IF, snap.pc, snap.inst);
            end
        end
        run_until_hs(2, 0);
        n_checks++;
        if (hs_log.size() < 2 || snap.pc !== RV || hs_log[1] !== snap.pc + 32'd4) begin
            n_errors++;
            $display("FAIL stall_next: got %h expected %h", hs_log.size() > 1 ? hs_log[1] : 32'hx, RV + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        lat_lo = 3; lat_hi = 3;
        do_reset();
        run_until_hs(1, 0);
        step(1, 32'h0000_1000, 0, 1, 0);
        run_until_hs(2, 0);
        n_checks++;
        if (hs_log.size() < 2 || hs_log[1] !== 32'h0000_1000 || dlv_log.size() != 0) begin
            n_errors++;
            $display("FAIL redir_wait: got req=%h dlv=%0d expected 00001000 0",
                     hs_log.size() > 1 ? hs_log[1] : 32'hx, dlv_log.size());
        end
    endtask

    task automatic test_redirect_hs();
        lat_lo = 0; lat_hi = 2;
        do_reset();
        for (int i = 0; i < 5 && imem_req_valid !== 1'b1; i++) step(0, '0, 0, 0, 0);
        step(1, 32'h0000_2002, 0, 1, 0);
        run_until_hs(2, 0);
        n_checks++;
        if (hs_log.size() < 2 || hs_log[0] !== RV || hs_log[1] !== 32'h0000_2000 || dlv_log.size() != 0) begin
            n_errors++;
            $display("FAIL redir_hs: got req0=%h req1=%h dlv=%0d expected %h 00002000 0",
                     hs_log.size() > 0 ? hs_log[0] : 32'hx, hs_log.size() > 1 ? hs_log[1] : 32'hx,
                     dlv_log.size(), RV);
        end
    endtask

    task automatic test_fault();
        lat_lo = 0; lat_hi = 0;
        do_reset();
        for (int i = 0; i < 20 && dlv_log.size() == 0; i++) step(0, '0, 1, 1, 1);
        step(0, '0, 1, 1, 0);
        n_checks++;
        if (fetch_fault_IF !== 1'b1 || inst_IF !== NOP || PC_IF !== RV || inst_valid_IF !== 1'b1) begin
            n_errors++;
            $display("FAIL fault_out: got f=%b inst=%h pc=%h v=%b expected 1 %h %h 1",
                     fetch_fault_IF, inst_IF, PC_IF, inst_valid_IF, NOP, RV);
        end
        step(1, 32'h0000_4000, 0, 1, 0);
        step(0, '0, 0, 1, 0);
        n_checks++;
        if (fetch_fault_IF !== 1'b0 || inst_valid_IF !== 1'b0) begin
            n_errors++;
            $display("FAIL fault_clear: got f=%b v=%b expected 0 0", fetch_fault_IF, inst_valid_IF);
        end
    endtask

    task automatic test_wrap();
        lat_lo = 0; lat_hi = 1;
        do_reset();
        step(1, 32'hFFFF_FFFF, 0, 0, 0);
        run_until_hs(2, 0);
        n_checks++;
        if (hs_log.size() < 2 || hs_log[0] !== 32'hFFFF_FFFC || hs_log[1] !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap: got %h %h expected fffffffc 00000000",
                     hs_log.size() > 0 ? hs_log[0] : 32'hx, hs_log.size() > 1 ? hs_log[1] : 32'hx);
        end
    endtask

    task automatic test_reset_in_wait();
        lat_lo = 0; lat_hi = 0;
        do_reset();
        step(1, 32'h0000_3000, 0, 0, 0);
        for (int i = 0; i < 20 && exp_q.size() == 0; i++) step(0, '0, 1, 1, 0);
        step(0, '0, 1, 1, 0);
        lat_lo = 3; lat_hi = 3;
        run_until_hs(2, 0);
        n_checks++;
        if (PC_IF !== 32'h0000_3000 || hs_log.size() < 2 || hs_log[1] !== 32'h0000_3004) begin
            n_errors++;
            $display("FAIL pre_reset: got pc=%h expected 00003000", PC_IF);
        end
        #2;
        reset = 1;
        drive_idle();
        clear_model();
        #1;
        n_checks++;
        if (PC_IF !== RV || inst_IF !== NOP || inst_valid_IF !== 1'b0 ||
            fetch_fault_IF !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got pc=%h inst=%h v=%b f=%b req=%b expected %h %h 0 0 0",
                     PC_IF, inst_IF, inst_valid_IF, fetch_fault_IF, imem_req_valid, RV, NOP);
        end
        @(negedge clk);
        reset = 0;
        lat_lo = 0; lat_hi = 0;
        run_until_hs(1, 0);
        n_checks++;
        if (hs_log.size() < 1 || hs_log[0] !== RV) begin
            n_errors++;
            $display("FAIL reset_refetch: got %h expected %h", hs_log.size() > 0 ? hs_log[0] : 32'hx, RV);
        end
    endtask

    task automatic test_random();
        int total;
        lat_lo = 0; lat_hi = 3;
        do_reset();
        total = 0;
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
            total += dlv_log.size();
            dlv_log.delete();
        end
        n_checks++;
        if (total < 100) begin
            n_errors++;
            $display("FAIL random_progress: got %0d deliveries expected at least 100", total);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1;
        drive_idle();
        clear_model();
        lat_lo = 0; lat_hi = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_hs();
        test_fault();
        test_wrap();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
